// File: rtl/keypad_scan_if.sv
// Key-event handshake between the keypad scanner (master) and its consumer (slave).
// Carries the FIFO head, valid/ready pair, fill level and sticky overflow.
interface keypad_scan_if #(
    parameter int CODE_W = 4,
    parameter int CNT_W  = 3
);
    logic [CODE_W-1:0] key_code;
    logic              key_valid;
    logic              key_ready;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              overflow;
    logic              ovf_clr;

    modport master (
        output key_code, key_valid, fifo_cnt, overflow,
        input  key_ready, ovf_clr
    );

    modport slave (
        input  key_code, key_valid, fifo_cnt, overflow,
        output key_ready, ovf_clr
    );
endinterface

// File: rtl/keypad_scan.sv
// Matrix keypad scanner: column-walk scan, press/release debounce, optional
// auto-repeat, and a first-word-through key-event FIFO with sticky overflow.
module keypad_scan #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int REPEAT_DLY = 0
) (
    input  logic            clk_1k,
    input  logic            rst,
    input  logic [ROWS-1:0] kbrow,
    input  logic            lock,
    output logic [COLS-1:0] kbcol,
    keypad_scan_if.master   ev
);
    localparam int CODE_W = $clog2(ROWS*COLS);
    localparam int CIW    = $clog2(COLS);
    localparam int PW     = $clog2(FIFO_DEPTH);
    // Press/release acceptance fires on the db_cnt value that completes DEBOUNCE stable samples,
    // counting the SCAN/HOLD sample that entered the debounce state.
    localparam logic [7:0]  DB_LAST  = 8'((DEBOUNCE >= 2) ? DEBOUNCE - 2 : 0);
    localparam logic [15:0] REP_LAST = 16'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
    localparam logic [PW:0] DEPTH_C  = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, SCAN, PRESS_DB, HOLD, REL_DB} state_t;

    state_t            state, state_n;
    logic [CIW-1:0]    col_idx, col_idx_n;
    logic [COLS-1:0]   kbcol_n;
    logic [7:0]        db_cnt, db_cnt_n;
    logic [15:0]       rep_cnt, rep_cnt_n;
    logic [ROWS-1:0]   cap_pat, cap_pat_n;
    logic [CODE_W-1:0] cap_code, cap_code_n;
    logic              push;

    int                low_cnt;
    logic [CODE_W-1:0] scan_code;

    always_comb begin
        low_cnt   = 0;
        scan_code = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!kbrow[r]) begin
                low_cnt   = low_cnt + 1;
                scan_code = CODE_W'(r*COLS + int'(col_idx));
            end
        end
    end

    always_comb begin
        state_n    = state;
        col_idx_n  = col_idx;
        kbcol_n    = kbcol;
        db_cnt_n   = db_cnt;
        rep_cnt_n  = rep_cnt;
        cap_pat_n  = cap_pat;
        cap_code_n = cap_code;
        push       = 1'b0;
        if (lock) begin
            state_n   = IDLE;
            kbcol_n   = '0;
            col_idx_n = '0;
            db_cnt_n  = '0;
            rep_cnt_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    kbcol_n = '0;
                    // A key still held from before keeps us here until it is released.
                    if (&kbrow) begin
                        state_n   = SCAN;
                        col_idx_n = '0;
                        kbcol_n   = {{(COLS-1){1'b1}}, 1'b0};
                    end
                end
                SCAN: begin
                    if (low_cnt == 1) begin
                        state_n    = PRESS_DB;
                        cap_pat_n  = kbrow;
                        cap_code_n = scan_code;
                        db_cnt_n   = '0;
                    end else if (low_cnt == 0 && col_idx != CIW'(COLS-1)) begin
                        col_idx_n = col_idx + 1'b1;
                        kbcol_n   = ~(COLS'(1) << col_idx_n);
                    end else begin
                        state_n = IDLE;
                        kbcol_n = '0;
                    end
                end
                PRESS_DB: begin
                    if (kbrow == cap_pat) begin
                        db_cnt_n = db_cnt + 1'b1;
                        if (db_cnt == DB_LAST) begin
                            push      = 1'b1;
                            state_n   = HOLD;
                            rep_cnt_n = '0;
                        end
                    end else begin
                        state_n = IDLE;
                        kbcol_n = '0;
                    end
                end
                HOLD: begin
                    if (&kbrow) begin
                        state_n  = REL_DB;
                        db_cnt_n = '0;
                    end else if (REPEAT_DLY > 0) begin
                        if (rep_cnt == REP_LAST) begin
                            push      = 1'b1;
                            rep_cnt_n = '0;
                        end else begin
                            rep_cnt_n = rep_cnt + 1'b1;
                        end
                    end
                end
                REL_DB: begin
                    if (!(&kbrow)) begin
                        state_n = HOLD;
                    end else if (db_cnt == DB_LAST) begin
                        state_n = IDLE;
                        kbcol_n = '0;
                    end else begin
                        db_cnt_n = db_cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    kbcol_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1k or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            col_idx  <= '0;
            kbcol    <= '0;
            db_cnt   <= '0;
            rep_cnt  <= '0;
            cap_pat  <= '1;
            cap_code <= '0;
        end else begin
            state    <= state_n;
            col_idx  <= col_idx_n;
            kbcol    <= kbcol_n;
            db_cnt   <= db_cnt_n;
            rep_cnt  <= rep_cnt_n;
            cap_pat  <= cap_pat_n;
            cap_code <= cap_code_n;
        end
    end

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       cnt;
    logic              valid, full, pop, wr_en, drop, ovf;

    assign valid = (cnt != '0);
    assign full  = (cnt == DEPTH_C);
    assign pop   = valid & ev.key_ready;
    // A simultaneous pop frees the slot, so a push on a full FIFO still lands.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk_1k) begin
        if (wr_en) mem[wr_ptr] <= cap_code;
    end

    always_ff @(posedge clk_1k or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            ovf <= drop | (ovf & ~ev.ovf_clr);
        end
    end

    assign ev.key_valid = valid;
    assign ev.key_code  = valid ? mem[rd_ptr] : '0;
    assign ev.fifo_cnt  = cnt;
    assign ev.overflow  = ovf;
endmodule
